// File: rtl/irq_traffic_cpu.sv
// irq_traffic_cpu: per-channel PRNG-paced IRQ traffic generators plus change-counting receivers.
// Define IRQ_TRAFFIC_CPU_TRACE_EN to print driven/received IRQ values and the finish event.
module irq_traffic_cpu #(
    parameter int          NUM_CHANNELS   = 4,
    parameter int          IRQ_WIDTH      = 32,
    parameter int          TRANSACTION_NB = 1000,
    parameter int          WAIT_BITS      = 4,
    parameter logic [63:0] SEED_BASE      = 64'hdeadbeefdeadbeef
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [31:0]                       cpu_index,
    input  logic                              i_en,
    input  logic [NUM_CHANNELS*IRQ_WIDTH-1:0] i_irq,
    output logic [NUM_CHANNELS*IRQ_WIDTH-1:0] o_irq,
    output logic [NUM_CHANNELS-1:0]           o_irq_valid,
    output logic                              o_finish
);

    localparam int               CNT_W       = $clog2(TRANSACTION_NB + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TRANSACTION_NB);
    localparam logic [63:0]      SEED_STRIDE = 64'h9E3779B97F4A7C15;

    typedef enum logic [1:0] {
        TX_LOAD,
        TX_WAIT,
        TX_DRIVE,
        TX_DONE
    } txState_e;

    function automatic logic [63:0] prngStep(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        t = t ^ (t >> 12);
        t = t ^ (t << 25);
        t = t ^ (t >> 27);
        return t * 64'h5821657736338717;
    endfunction

    logic [NUM_CHANNELS-1:0] chDone;
    logic                    finish_q;
    logic                    finish_d;

`ifdef IRQ_TRAFFIC_CPU_TRACE_EN
    logic [31:0] cpuIdx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpuIdx_q <= cpu_index;
        end
    end
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : gChannel
        localparam logic [63:0] CH_OFFSET = 64'(c) * SEED_STRIDE;

        logic [63:0]          x_q;
        logic [63:0]          x_d;
        txState_e             txState_q;
        logic [WAIT_BITS-1:0] waitCnt_q;
        logic [WAIT_BITS-1:0] loadWait;
        logic [IRQ_WIDTH-1:0] pendIrq_q;
        logic [IRQ_WIDTH-1:0] irq_q;
        logic                 valid_q;
        logic [IRQ_WIDTH-1:0] prevIrq_q;
        logic [IRQ_WIDTH-1:0] rxIrq;
        logic [CNT_W-1:0]     rxCnt_q;

        assign rxIrq     = i_irq[c*IRQ_WIDTH +: IRQ_WIDTH];
        assign x_d       = prngStep(x_q);
        assign loadWait  = x_q[WAIT_BITS-1:0];
        assign chDone[c] = (rxCnt_q == CNT_MAX);

        assign o_irq[c*IRQ_WIDTH +: IRQ_WIDTH] = irq_q;
        assign o_irq_valid[c]                  = valid_q;

        // Whole TX pipeline freezes while disabled; the valid pulse is cleared every cycle.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                txState_q <= TX_LOAD;
                waitCnt_q <= '0;
                pendIrq_q <= '0;
                irq_q     <= '0;
                valid_q   <= 1'b0;
                x_q       <= SEED_BASE + {32'd0, cpu_index} + CH_OFFSET;
            end else begin
                valid_q <= 1'b0;
                if (i_en) begin
                    case (txState_q)
                        TX_LOAD: begin
                            if (chDone[c]) begin
                                txState_q <= TX_DONE;
                            end else begin
                                pendIrq_q <= x_q[IRQ_WIDTH-1:0];
                                x_q       <= x_d;
                                waitCnt_q <= loadWait;
                                txState_q <= (loadWait == '0) ? TX_DRIVE : TX_WAIT;
                            end
                        end
                        TX_WAIT: begin
                            waitCnt_q <= waitCnt_q - WAIT_BITS'(1);
                            if (waitCnt_q == WAIT_BITS'(1)) begin
                                txState_q <= TX_DRIVE;
                            end
                        end
                        TX_DRIVE: begin
                            irq_q     <= pendIrq_q;
                            valid_q   <= 1'b1;
                            txState_q <= chDone[c] ? TX_DONE : TX_LOAD;
`ifdef IRQ_TRAFFIC_CPU_TRACE_EN
                            $display("[cpu_%0d.%0d] o_irq = 0x%0h", cpuIdx_q, c, pendIrq_q);
`endif
                        end
                        default: begin
                            txState_q <= TX_DONE;
                        end
                    endcase
                end
            end
        end

        // Receiver counts changes regardless of i_en and saturates once the channel is done.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                prevIrq_q <= '0;
                rxCnt_q   <= '0;
            end else begin
                prevIrq_q <= rxIrq;
                if ((rxIrq != prevIrq_q) && !chDone[c]) begin
                    rxCnt_q <= rxCnt_q + CNT_W'(1);
`ifdef IRQ_TRAFFIC_CPU_TRACE_EN
                    $display("[cpu_%0d.%0d] i_irq = 0x%0h (%0d/%0d)", cpuIdx_q, c, rxIrq,
                             rxCnt_q + CNT_W'(1), TRANSACTION_NB);
`endif
                end
            end
        end
    end

    assign finish_d = finish_q | (&chDone);

    // Finish is sticky until the next reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            finish_q <= 1'b0;
        end else begin
            finish_q <= finish_d;
`ifdef IRQ_TRAFFIC_CPU_TRACE_EN
            if (!finish_q && (&chDone)) begin
                $display("[cpu_%0d] o_finish: all %0d channels done", cpuIdx_q, NUM_CHANNELS);
            end
`endif
        end
    end

    assign o_finish = finish_q;

endmodule

// File: tb/tb_irq_traffic_cpu.sv
// tb_irq_traffic_cpu: randomized scoreboard bench for irq_traffic_cpu against a schedule-level model.
module tb_irq_traffic_cpu;

    localparam int          NC          = 4;
    localparam int          W           = 32;
    localparam int          NB          = 3;
    localparam int          WB          = 4;
    localparam logic [63:0] SEED_BASE   = 64'hdeadbeefdeadbeef;
    localparam logic [63:0] SEED_STRIDE = 64'h9E3779B97F4A7C15;

    typedef struct {
        int unsigned cyc;
        int          ch;
        logic [W-1:0] v;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [31:0]     cpu_index;
    logic            i_en;
    logic [NC*W-1:0] i_irq;
    logic [NC*W-1:0] o_irq;
    logic [NC-1:0]   o_irq_valid;
    logic            o_finish;

    int unsigned vectors;
    int unsigned miscompares;
    int unsigned edgeCount;
    bit          started;

    exp_t            expQ[$];
    logic [63:0]     mx      [NC];
    int              remain  [NC];
    int              full    [NC];
    bit              stopped [NC];
    logic [W-1:0]    pendV   [NC];
    int              rxCnt   [NC];
    logic [W-1:0]    prevIrq [NC];
    logic [NC*W-1:0] modelIrq;
    bit              modelFinish;

    irq_traffic_cpu #(
        .NUM_CHANNELS  (NC),
        .IRQ_WIDTH     (W),
        .TRANSACTION_NB(NB),
        .WAIT_BITS     (WB),
        .SEED_BASE     (SEED_BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_index  (cpu_index),
        .i_en       (i_en),
        .i_irq      (i_irq),
        .o_irq      (o_irq),
        .o_irq_valid(o_irq_valid),
        .o_finish   (o_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] refStep(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        t ^= t >> 12;
        t ^= t << 25;
        t ^= t >> 27;
        return t * 64'h5821657736338717;
    endfunction

    // A transaction draws its wait and value from the current seed; the output lands w+2 enabled edges later.
    function automatic void startTxn(input int c);
        full[c]   = int'(mx[c][WB-1:0]) + 2;
        remain[c] = full[c];
        pendV[c]  = mx[c][W-1:0];
        mx[c]     = refStep(mx[c]);
    endfunction

    task automatic checkOutput(input string name, input logic [NC*W-1:0] act, input logic [NC*W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeCount);
        end
    endtask

    // Reference model: advances the expected schedule on every edge and pushes expected pulses.
    always @(posedge clk) begin : refModel
        bit           doneBefore [NC];
        bit           allBefore;
        logic [W-1:0] s;
        edgeCount++;
        if (!rst_n) begin
            started     = 1'b1;
            modelFinish = 1'b0;
            modelIrq    = '0;
            for (int c = 0; c < NC; c++) begin
                mx[c]      = SEED_BASE + {32'd0, cpu_index} + 64'(c) * SEED_STRIDE;
                stopped[c] = 1'b0;
                rxCnt[c]   = 0;
                prevIrq[c] = '0;
                startTxn(c);
            end
        end else if (started) begin
            allBefore = 1'b1;
            for (int c = 0; c < NC; c++) begin
                doneBefore[c] = (rxCnt[c] == NB);
                allBefore     = allBefore & doneBefore[c];
            end
            if (i_en) begin
                for (int c = 0; c < NC; c++) begin
                    if (!stopped[c]) begin
                        if (remain[c] == full[c] && doneBefore[c]) begin
                            stopped[c] = 1'b1;
                        end else begin
                            remain[c]--;
                            if (remain[c] == 0) begin
                                expQ.push_back('{edgeCount, c, pendV[c]});
                                modelIrq[c*W +: W] = pendV[c];
                                if (doneBefore[c]) stopped[c] = 1'b1;
                                else startTxn(c);
                            end
                        end
                    end
                end
            end
            for (int c = 0; c < NC; c++) begin
                s = i_irq[c*W +: W];
                if (s != prevIrq[c] && rxCnt[c] < NB) rxCnt[c]++;
                prevIrq[c] = s;
            end
            if (allBefore) modelFinish = 1'b1;
        end
    end

    // Monitor: pops the scoreboard for each pulse and flags missed or unexpected ones.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (started) begin
            while (expQ.size() > 0 && expQ[0].cyc < edgeCount) begin
                e = expQ.pop_front();
                vectors++;
                miscompares++;
                $display("[TB] FAIL missed pulse ch%0d: got no pulse at edge %0d, expected value 0x%0h", e.ch, e.cyc, e.v);
            end
            for (int c = 0; c < NC; c++) begin
                if (o_irq_valid[c] === 1'b1) begin
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected pulse ch%0d: got value 0x%0h at edge %0d, expected none", c, o_irq[c*W +: W], edgeCount);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("pulse channel", (NC*W)'(c), (NC*W)'(e.ch));
                        checkOutput("pulse edge", (NC*W)'(edgeCount), (NC*W)'(e.cyc));
                        checkOutput("pulse value", (NC*W)'(o_irq[c*W +: W]), (NC*W)'(e.v));
                    end
                end
            end
            checkOutput("o_irq", o_irq, modelIrq);
            checkOutput("o_finish", (NC*W)'(o_finish), (NC*W)'(modelFinish));
        end
    end

    task automatic applyStimulus(input int n, input int enPct, input int chgPct);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_en = ($urandom_range(99) < enPct);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(99) < chgPct) i_irq[c*W +: W] = $urandom;
            end
        end
    endtask

    task automatic doReset(input logic [31:0] idx, input int n);
        @(negedge clk);
        rst_n     = 1'b0;
        cpu_index = idx;
        repeat (n) @(negedge clk);
        checkOutput("reset o_irq", o_irq, '0);
        checkOutput("reset o_irq_valid", (NC*W)'(o_irq_valid), '0);
        checkOutput("reset o_finish", (NC*W)'(o_finish), '0);
        rst_n = 1'b1;
        i_en  = 1'b1;
    endtask

    initial begin : driver
        logic [63:0] seed5;
        bit          seen;
        vectors     = 0;
        miscompares = 0;
        edgeCount   = 0;
        started     = 1'b0;
        rst_n       = 1'b0;
        cpu_index   = '0;
        i_en        = 1'b0;
        i_irq       = '0;

        // Free-running traffic with random enable, no receive activity.
        doReset(32'd0, 3);
        applyStimulus(300, 85, 0);

        // Long enable drop, then resume.
        applyStimulus(5, 100, 0);
        applyStimulus(10, 0, 0);
        applyStimulus(60, 100, 0);

        // One-cycle reset mid-transaction; first channel-0 value comes straight from the seed.
        applyStimulus(7, 100, 0);
        doReset(32'd5, 1);
        seed5 = SEED_BASE + 64'd5;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (o_irq_valid[0] === 1'b1) begin
                seen = 1'b1;
                checkOutput("first v after idx5 reset", (NC*W)'(o_irq[W-1:0]), (NC*W)'(seed5[W-1:0]));
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL first pulse timeout: got no ch0 pulse in 40 cycles, expected one");
        end

        // cpu_index=1 makes channel 0's first wait zero.
        doReset(32'd1, 2);
        applyStimulus(100, 100, 0);

        // Channel 0 counted to done by three consecutive changes, then all slices together.
        doReset(32'd0, 2);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            i_irq[0 +: W] = W'(k);
        end
        applyStimulus(5, 100, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) i_irq[c*W +: W] = W'(32'h1000 * (k + 1) + c + 16);
        end
        applyStimulus(150, 100, 0);

        // Random receive activity with random enable.
        doReset(32'd2, 2);
        applyStimulus(400, 70, 3);
        applyStimulus(50, 100, 0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", (NC*W)'(expQ.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
